piso_serializer: RTL and testbench

PISO_SERIALIZER -- requirements
Module: piso_serializer

---
 rtl/piso_serializer.sv | 98 +++++++++
 tb/tb_piso_serializer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in / serial-out serializer with a valid/ready load port.
// A new word can be accepted while the previous frame's last bit is on Dout, so frames stream with no gap.
module piso_serializer #(
  parameter int   WIDTH     = 4,
  parameter bit   LSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             din_valid,
  input  logic [WIDTH-1:0] din,
  output logic             din_ready,
  output logic             Dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shift, w_shift_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             r_dout, w_dout_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_done, w_done_nxt;
  logic             w_last;
  logic             w_ready;
  logic             w_xfer;
  logic             w_first_bit;
  logic [WIDTH-1:0] w_load;

  // r_cnt counts bits still to send after the one currently on Dout.
  assign w_last      = (r_state == S_SHIFT) && (r_cnt == '0);
  assign w_ready     = !clr && ((r_state == S_IDLE) || w_last);
  assign w_xfer      = w_ready && din_valid;
  assign w_first_bit = LSB_FIRST ? din[0] : din[WIDTH-1];
  assign w_load      = LSB_FIRST ? (din >> 1) : (din << 1);

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_dout_nxt  = r_dout;
    w_valid_nxt = r_valid;
    w_done_nxt  = r_done;
    if (w_xfer) begin
      w_state_nxt = S_SHIFT;
      w_shift_nxt = w_load;
      w_cnt_nxt   = CW'(WIDTH - 1);
      w_dout_nxt  = w_first_bit;
      w_valid_nxt = 1'b1;
      w_done_nxt  = 1'b0;
    end else if (w_last) begin
      w_state_nxt = S_IDLE;
      w_shift_nxt = '0;
      w_cnt_nxt   = '0;
      w_dout_nxt  = IDLE_BIT;
      w_valid_nxt = 1'b0;
      w_done_nxt  = 1'b0;
    end else if (r_state == S_SHIFT) begin
      w_dout_nxt  = LSB_FIRST ? r_shift[0] : r_shift[WIDTH-1];
      w_shift_nxt = LSB_FIRST ? (r_shift >> 1) : (r_shift << 1);
      w_cnt_nxt   = r_cnt - CW'(1);
      w_done_nxt  = (r_cnt == CW'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_dout  <= IDLE_BIT;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dout  <= w_dout_nxt;
      r_valid <= w_valid_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign din_ready  = w_ready;
  assign Dout       = r_dout;
  assign dout_valid = r_valid;
  assign busy       = r_valid;
  assign done       = r_done;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: an LSB-first/idle-0 and an MSB-first/idle-1 instance share one stimulus stream.
// Expected serial bits are queued at acceptance and popped by a monitor whenever dout_valid is seen.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       din_valid = 1'b0;
  logic [3:0] din = '0;

  logic rdy1, d1, v1, b1, dn1;
  logic rdy2, d2, v2, b2, dn2;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_lsb (
    .clk(clk), .clr(clr), .din_valid(din_valid), .din(din),
    .din_ready(rdy1), .Dout(d1), .dout_valid(v1), .busy(b1), .done(dn1)
  );

  piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_msb (
    .clk(clk), .clr(clr), .din_valid(din_valid), .din(din),
    .din_ready(rdy2), .Dout(d2), .dout_valid(v2), .busy(b2), .done(dn2)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [1:0] q1[$];
  logic [1:0] q2[$];
  logic mon_en = 1'b0;
  int run_len = 0, max_run = 0, done_cnt = 0;
  logic [3:0] ds = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic mon(input int idx, input logic v, input logic b, input logic d,
                     input logic dn, input logic idle_bit);
    logic [1:0] e;
    chk($sformatf("busy_eq_valid%0d", idx), 32'(b), 32'(v));
    if (v) begin
      if ((idx == 1 ? q1.size() : q2.size()) == 0) begin
        chk($sformatf("unexpected_valid%0d", idx), 32'(v), 32'(0));
      end else begin
        e = (idx == 1) ? q1.pop_front() : q2.pop_front();
        chk($sformatf("dout%0d", idx), 32'(d), 32'(e[1]));
        chk($sformatf("done%0d", idx), 32'(dn), 32'(e[0]));
      end
    end else begin
      chk($sformatf("idle_dout%0d", idx), 32'(d), 32'(idle_bit));
      chk($sformatf("idle_done%0d", idx), 32'(dn), 32'(0));
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon(1, v1, b1, d1, dn1, 1'b0);
      mon(2, v2, b2, d2, dn2, 1'b1);
      if (v1) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
      end else begin
        run_len = 0;
      end
      if (dn1) done_cnt++;
    end
  end

  // Downstream right-shift register fed serially at its MSB.
  always @(posedge clk) if (v1) ds <= {d1, ds[3:1]};

  // lseq/mseq list the bits in transmit order, first bit in [3].
  task automatic send(input logic [3:0] w, input logic [3:0] lseq, input logic [3:0] mseq);
    din = w;
    din_valid = 1'b1;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (rdy1 && !clr) begin
        chk("ready_agree", 32'(rdy2), 32'(rdy1));
        for (int i = 3; i >= 0; i--) begin
          q1.push_back({lseq[i], i == 0});
          q2.push_back({mseq[i], i == 0});
        end
        @(posedge clk); #1;
        return;
      end
    end
    chk("accept_timeout", 32'(rdy1), 32'(1));
  endtask

  task automatic idle_cycles(input int n);
    din_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with a word offered: nothing may be accepted while clr is high.
    clr = 1'b1; din_valid = 1'b1; din = 4'hF;
    @(posedge clk); #1;
    mon_en = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rdy_in_clr1", 32'(rdy1), 32'(0));
      chk("rdy_in_clr2", 32'(rdy2), 32'(0));
    end
    @(posedge clk); #1;
    clr = 1'b0;

    // Single word, accepted on the first edge after clr drops.
    send(4'b1001, 4'b1001, 4'b1001);
    idle_cycles(6);
    chk("downstream_q", 32'(ds), 32'(4'b1001));
    chk("single_done_cnt", 32'(done_cnt), 32'(1));

    // Back-to-back frames with din_valid held.
    max_run = 0; done_cnt = 0;
    send(4'b0110, 4'b0110, 4'b0110);
    send(4'b1110, 4'b0111, 4'b1110);
    idle_cycles(8);
    chk("b2b_run_len", 32'(max_run), 32'(8));
    chk("b2b_done_cnt", 32'(done_cnt), 32'(2));

    // Bit order on both instances.
    send(4'b1000, 4'b0001, 4'b1000);
    idle_cycles(6);

    // Stall: toggle din_valid and change din while the frame is in flight.
    send(4'b0101, 4'b1010, 4'b0101);
    for (int i = 0; i < 3; i++) begin
      din_valid = (i % 2 == 0);
      din = 4'hA ^ 4'(i);
      @(posedge clk); #1;
    end
    idle_cycles(6);

    // Abort after the second bit of 4'b1011.
    done_cnt = 0;
    send(4'b1011, 4'b1101, 4'b1011);
    @(posedge clk); #1;
    clr = 1'b1; din_valid = 1'b1; din = 4'hF;
    @(negedge clk);
    chk("rdy_mid_clr", 32'(rdy1), 32'(0));
    @(posedge clk); #1;
    q1.delete();
    q2.delete();
    @(negedge clk);
    chk("abort_valid", 32'(v1), 32'(0));
    chk("abort_dout", 32'(d1), 32'(0));
    @(posedge clk); #1;
    clr = 1'b0; din_valid = 1'b0;
    idle_cycles(6);
    chk("abort_no_done", 32'(done_cnt), 32'(0));

    // Resume after abort.
    send(4'b0011, 4'b1100, 4'b0011);
    idle_cycles(8);
    chk("drain_q1", 32'(q1.size()), 32'(0));
    chk("drain_q2", 32'(q2.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
